rr_arbiter_8x3: RTL
===================

# rr_arbiter_8x3

Round-robin arbiter that shares one resource among 8 requesters. It outputs a one-hot grant plus its 3-bit binary index, using the same bit-k-to-index-k mapping as the 8x3 encoder. A grant is held while the winner keeps its request asserted. A hold-time limit bounds the hold, and fairness rotates past each served requester. The block sits in front of any single-user datapath (encoder, bus, shared register port) and drives its select and enable.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may stay valid. 0 means unlimited. Legal range is 0..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- en   input  1  arbiter enable. When low, no new grant is issued and any held grant is released.
- req  input  8  request vector; req[k] high means requester k wants the resource.
- gnt  output 8  one-hot grant, registered. All zero when not granting.
- y    output 3  binary index of the set gnt bit, registered. Forced to 0 when valid=0.
- valid output 1 high while a grant is active, registered.

## Operation
- State register with two states:
  - IDLE: gnt=0, y=0, valid=0.
  - GRANT: exactly one gnt bit is set, y = its index, valid=1.
- Internal registers:
  - ptr[2:0]: highest-priority index.
  - hold_cnt[7:0]: cycles spent in the current grant.
- IDLE → GRANT when en=1 and req≠0 at an edge.
  - Winner = first set req bit in circular order ptr, ptr+1, …, ptr+7 (mod 8).
  - hold_cnt loads 1.
- GRANT → IDLE at an edge if any of the following holds:
  - req[y]=0;
  - en=0;
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD.
- Otherwise GRANT stays and hold_cnt increments, saturating at 255.
- On every GRANT → IDLE transition, ptr ← y+1 mod 8 (index 7 wraps to 0). The released requester becomes lowest priority, including on timeout and en drop.
- GRANT never moves directly to another GRANT. There is always at least one IDLE bubble cycle between grants.
- Requests from non-granted requesters have no effect during GRANT.
- en=0 in IDLE keeps the block in IDLE; ptr is unchanged.
- rst=1: state=IDLE, ptr=0, hold_cnt=0, gnt=0, y=0, valid=0 at that edge, regardless of state. rst takes precedence over all other inputs.
- Pure combinational decode of req is not used for outputs. All outputs come straight from flops.

## Timing
- Request-to-grant latency:
  - req seen in IDLE at edge n → gnt/y/valid valid after edge n.
  - For req rising between edges n−1 and n, the grant is visible in cycle n+1.
- Release latency: req[y] dropped before edge m → valid=0 after edge m (one cycle).
- Grant duration with req held, MAX_HOLD=H≠0: valid is high for exactly H cycles, then low for exactly 1 cycle, then the next winner is granted if any request is pending.
- Back-to-back throughput under saturation: one grant per H+1 cycles.
- Simultaneous events in GRANT:
  - Release and a new request at the same edge: release first; the new request is evaluated at the next edge with the updated ptr.
  - en=0 and rst=1 together: reset behaviour.
- Reset mid-grant: outputs drop after the reset edge. The first post-reset grant uses ptr=0.

## Structure
- Shared package arb_pkg holds:
  - N_REQ=8, IDX_W=3;
  - state enum {IDLE, GRANT};
  - HOLD_W=8.
- Sub-module rr_pick_8, combinational:
  - inputs req[7:0], ptr[2:0];
  - outputs pick_oh[7:0], pick_idx[2:0], any.
  - Implementation: rotate, fixed-priority, rotate back.
- The top level holds the FSM, ptr, hold_cnt and output registers.

## Test plan
- Reset, then en=1, req=8'h01 held 5 cycles:
  - gnt=8'h01, y=0, valid=1 from the cycle after the first sampled edge;
  - valid stays high while req is held;
  - req dropped → valid=0 one edge later, ptr=1.
- MAX_HOLD=4, en=1, req=8'hFF constant from reset:
  - y sequence 0,1,2,…,7,0;
  - each index valid for exactly 4 cycles;
  - a 1-cycle valid=0 bubble between grants.
- Wrap: ptr=7 reached, req=8'h81:
  - grant y=7;
  - on release, ptr=0 and next grant y=0;
  - then ptr=1 and next grant y=7.
- en toggles mid-grant (y=2, req=8'h04 held):
  - en=0 → valid=0 after that edge;
  - no grant while en=0;
  - en=1 → y=2 re-granted, since ptr=3 and only requester 2 is pending.
- rst=1 mid-grant (y=4, req=8'h14 held):
  - all outputs 0 after the edge;
  - after rst falls, grant y=2, because ptr=0 and bit 2 is the first set bit.
- Simultaneous: in GRANT y=3, req changes 8'h08→8'h20 in one cycle:
  - valid=0 for 1 cycle;
  - then y=5 granted with ptr=4.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Registered grant payload driven onto the bus
  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] y;
    logic             valid;
  } grant_t;

  localparam grant_t GRANT_NONE = '{gnt: '0, y: '0, valid: 1'b0};

  // Saturating hold counter increment
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == {HOLD_W{1'b1}}) ? v : v + HOLD_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8x3_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8x3_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] y;
  logic             valid;

  modport master (output en, output req, input gnt, input y, input valid);
  modport slave  (input en, input req, output gnt, output y, output valid);

endinterface

// File: rtl/rr_pick_8.sv
// Combinational round-robin pick: rotate by ptr, fixed-priority, rotate back.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] rot_dbl;
  logic [2*N_REQ-1:0] back_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   fp_oh;
  logic [IDX_W-1:0]   fp_idx;

  // Bit 0 of rot is requester ptr, so lowest set bit is the winner
  assign rot_dbl = {req, req} >> ptr;
  assign rot     = rot_dbl[N_REQ-1:0];
  assign fp_oh   = rot & (~rot + N_REQ'(1));

  always_comb begin
    fp_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) fp_idx = IDX_W'(i);
    end
  end

  assign back_dbl = {fp_oh, fp_oh} << ptr;
  assign pick_oh  = back_dbl[2*N_REQ-1:N_REQ];
  assign pick_idx = fp_idx + ptr;
  assign any      = |req;

endmodule

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with bounded hold and registered one-hot/binary grant.
module rr_arbiter_8x3
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)(
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_8x3_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  grant_t            grant_q, grant_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              release_c;

  rr_pick_8 u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Hold ends on request drop, enable drop or reaching the hold limit
  assign release_c = !bus.req[grant_q.y] || !bus.en ||
                     ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= GRANT_NONE;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        grant_d = GRANT_NONE;
        if (bus.en && pick_any) begin
          state_d    = GRANT;
          grant_d    = '{gnt: pick_oh, y: pick_idx, valid: 1'b1};
          hold_cnt_d = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          // Released requester drops to lowest priority; always one idle bubble
          state_d    = IDLE;
          grant_d    = GRANT_NONE;
          ptr_d      = grant_q.y + IDX_W'(1);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  assign bus.gnt   = grant_q.gnt;
  assign bus.y     = grant_q.y;
  assign bus.valid = grant_q.valid;

endmodule
